// File: rtl/pio_edge_capture_db.sv
// Avalon-MM input PIO: synchronised, debounced inputs with programmable
// hold time, selectable edge capture, per-bit interrupt mask and one level IRQ.
module pio_edge_capture_db #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_BITS     = 16,
  parameter int DB_DEFAULT  = 0,
  parameter int EDGE_TYPE   = 0,
  parameter int BIT_CLEAR   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_RAW     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_DBLIMIT = 3'd4;
  localparam logic [DB_BITS-1:0] DB_RESET = DB_BITS'(DB_DEFAULT);

  logic               wr_en;
  logic [WIDTH-1:0]   sync_chain [SYNC_STAGES];
  logic [WIDTH-1:0]   sync;
  logic [WIDTH-1:0]   stable;
  logic [DB_BITS-1:0] cnt [WIDTH];
  logic [DB_BITS-1:0] dblimit;
  logic [WIDTH-1:0]   upd;
  logic [WIDTH-1:0]   edge_qual;
  logic [WIDTH-1:0]   edge_hit;
  logic [WIDTH-1:0]   cap_clr;
  logic [WIDTH-1:0]   edgecap;
  logic [WIDTH-1:0]   irqmask;
  logic [31:0]        rd_mux;
  logic               unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Metastability synchroniser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_chain[s] <= '0;
    end else begin
      sync_chain[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_chain[s] <= sync_chain[s-1];
    end
  end

  assign sync = sync_chain[SYNC_STAGES-1];

  // Debounce: a channel flips only after disagreeing for DBLIMIT+1 cycles in a row
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++)
      upd[i] = (sync[i] != stable[i]) && (cnt[i] == dblimit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          stable[i] <= sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_BITS'(1);
        end
      end
    end
  end

  // Edge qualification and capture; a new edge wins over a same-cycle clear
  always_comb begin
    if (EDGE_TYPE == 0)      edge_qual = sync;
    else if (EDGE_TYPE == 1) edge_qual = ~sync;
    else                     edge_qual = {WIDTH{1'b1}};
    edge_hit = upd & edge_qual;
  end

  always_comb begin
    cap_clr = '0;
    if (wr_en && address == ADDR_EDGECAP)
      cap_clr = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : {WIDTH{1'b1}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap <= '0;
      irqmask <= '0;
      dblimit <= DB_RESET;
    end else begin
      edgecap <= (edgecap & ~cap_clr) | edge_hit;
      if (wr_en && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
      if (wr_en && address == ADDR_DBLIMIT) dblimit <= writedata[DB_BITS-1:0];
    end
  end

  // Read path: registered every cycle from the presented address
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0]   = stable;
      ADDR_RAW:     rd_mux[WIDTH-1:0]   = sync;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0]   = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0]   = edgecap;
      ADDR_DBLIMIT: rd_mux[DB_BITS-1:0] = dblimit;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_pio_edge_capture_db.sv
// Scoreboard bench: three instances (rising/bit-clear, falling/bit-clear,
// any-edge/clear-all) share one bus; expected read and irq values are queued.
module tb_pio_edge_capture_db;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic        write_n;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rdata0, rdata1, rdata2;
  logic        irq0, irq1, irq2;

  always #5 clk = ~clk;

  pio_edge_capture_db #(.WIDTH(8), .SYNC_STAGES(2), .DB_BITS(16), .DB_DEFAULT(4),
                        .EDGE_TYPE(0), .BIT_CLEAR(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata0), .irq(irq0));

  pio_edge_capture_db #(.WIDTH(8), .SYNC_STAGES(2), .DB_BITS(16), .DB_DEFAULT(4),
                        .EDGE_TYPE(1), .BIT_CLEAR(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata1), .irq(irq1));

  pio_edge_capture_db #(.WIDTH(8), .SYNC_STAGES(2), .DB_BITS(16), .DB_DEFAULT(4),
                        .EDGE_TYPE(2), .BIT_CLEAR(0)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata2), .irq(irq2));

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [2:0]  m;
    string       n;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];
  exp_t mon_x;
  int   checks = 0;
  int   errors = 0;
  logic rd_issue = 1'b0;
  logic rd_seen  = 1'b0;
  logic irq_probe = 1'b0;

  always @(posedge clk) rd_seen <= rd_issue;

  task automatic score(input exp_t x, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2);
    logic [31:0] a [3];
    logic [31:0] e [3];
    a[0] = a0; a[1] = a1; a[2] = a2;
    e[0] = x.e0; e[1] = x.e1; e[2] = x.e2;
    for (int d = 0; d < 3; d++) begin
      if (x.m[d]) begin
        checks++;
        if (a[d] !== e[d]) begin
          errors++;
          $display("FAIL %s dut%0d got 0x%08h expected 0x%08h", x.n, d, a[d], e[d]);
        end
      end
    end
  endtask

  // Monitor: readdata is valid the cycle after a read was presented
  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_q_empty got read with no expectation");
      end else begin
        mon_x = rd_q.pop_front();
        score(mon_x, rdata0, rdata1, rdata2);
      end
    end
    if (irq_probe) begin
      if (irq_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL irq_q_empty got probe with no expectation");
      end else begin
        mon_x = irq_q.pop_front();
        score(mon_x, {31'b0, irq0}, {31'b0, irq1}, {31'b0, irq2});
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e0, input logic [31:0] e1,
                    input logic [31:0] e2, input string n);
    exp_t x;
    x.e0 = e0; x.e1 = e1; x.e2 = e2; x.m = 3'b111; x.n = n;
    rd_q.push_back(x);
    address = a; chipselect = 1'b1; write_n = 1'b1; rd_issue = 1'b1;
    tick();
    rd_issue = 1'b0; chipselect = 1'b0;
  endtask

  task automatic rda(input logic [2:0] a, input logic [31:0] e, input string n);
    rd(a, e, e, e, n);
  endtask

  task automatic chk_irq(input logic e0, input logic e1, input logic e2, input string n);
    exp_t x;
    x.e0 = {31'b0, e0}; x.e1 = {31'b0, e1}; x.e2 = {31'b0, e2}; x.m = 3'b111; x.n = n;
    irq_q.push_back(x);
    irq_probe = 1'b1;
    @(negedge clk);
    #1;
    irq_probe = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0; in_port = '0;
    tick(3);
    chk_irq(0, 0, 0, "rst_irq");
    rda(3'd0, 32'h0, "rst_rdata");
    reset_n = 1'b1;
    tick(2);
    rda(3'd0, 32'h0, "rst_data");
    rda(3'd1, 32'h0, "rst_raw");
    rda(3'd2, 32'h0, "rst_mask");
    rda(3'd3, 32'h0, "rst_cap");
    rda(3'd4, 32'h4, "rst_dblimit");

    // Test 1: DBLIMIT=0, capture at t+3
    wr(3'd2, 32'h01);
    wr(3'd4, 32'h0);
    in_port = 8'h01;
    tick(2);
    chk_irq(0, 0, 0, "t1_irq_t2");
    rd(3'd3, 32'h00, 32'h00, 32'h00, "t1_cap_t3_pre");
    chk_irq(1, 0, 1, "t1_irq_t3");
    rd(3'd3, 32'h01, 32'h00, 32'h01, "t1_cap");
    rda(3'd0, 32'h01, "t1_data");
    wr(3'd3, 32'hFF);

    // Test 2: DBLIMIT=4, 4-cycle glitch rejected, 5+ cycle level accepted
    wr(3'd4, 32'h4);
    in_port = 8'h09;
    tick(4);
    in_port = 8'h01;
    tick(8);
    rda(3'd0, 32'h01, "t2_glitch_data");
    rda(3'd3, 32'h00, "t2_glitch_cap");
    in_port = 8'h09;
    tick(6);
    rda(3'd0, 32'h01, "t2_data_t7_pre");
    rda(3'd0, 32'h09, "t2_data");
    rd(3'd3, 32'h08, 32'h00, 32'h08, "t2_cap");
    chk_irq(0, 0, 0, "t2_irq_masked");

    // Test 3: write-1-to-clear, and set beating a same-cycle clear
    wr(3'd4, 32'h0);
    in_port = 8'h0B;
    tick(4);
    rd(3'd3, 32'h0A, 32'h00, 32'h0A, "t3_cap_0a");
    wr(3'd3, 32'h02);
    rd(3'd3, 32'h08, 32'h00, 32'h00, "t3_clr_bit1");
    in_port = 8'h09;
    tick(4);
    in_port = 8'h0B;
    tick(2);
    wr(3'd3, 32'h02);
    rd(3'd3, 32'h0A, 32'h00, 32'h02, "t3_set_wins");
    rda(3'd0, 32'h0B, "t3_data");

    // Test 4: edge type selection on bit2
    wr(3'd3, 32'hFF);
    in_port = 8'h0F;
    tick(4);
    rd(3'd3, 32'h04, 32'h00, 32'h04, "t4_rise");
    wr(3'd3, 32'h04);
    in_port = 8'h0B;
    tick(4);
    rd(3'd3, 32'h00, 32'h04, 32'h04, "t4_fall");

    // Test 5: masking does not block capture; unmask raises irq next cycle
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h00);
    in_port = 8'h2B;
    tick(4);
    chk_irq(0, 0, 0, "t5_irq_masked");
    rd(3'd3, 32'h20, 32'h00, 32'h20, "t5_cap");
    wr(3'd2, 32'h20);
    chk_irq(1, 0, 1, "t5_irq_unmask");
    wr(3'd3, 32'h20);
    chk_irq(0, 0, 0, "t5_irq_cleared");
    rda(3'd2, 32'h20, "t5_mask_rb");
    rda(3'd4, 32'h0, "t5_dblimit_rb");
    wr(3'd5, 32'hFFFF_FFFF);
    rda(3'd5, 32'h0, "t5_addr5");
    rda(3'd7, 32'h0, "t5_addr7");
    rda(3'd1, 32'h2B, "t5_raw");
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'hFF);
    rda(3'd0, 32'h2B, "t5_data_ro");

    // Test 6: reset mid-debounce restarts the full hold time
    wr(3'd2, 32'hFF);
    in_port = 8'h2F;
    tick(4);
    chk_irq(1, 0, 1, "t6_irq_pre");
    wr(3'd4, 32'h4);
    in_port = 8'h6F;
    tick(5);
    reset_n = 1'b0;
    chk_irq(0, 0, 0, "t6_irq_in_rst");
    rda(3'd2, 32'h0, "t6_rdata_in_rst");
    reset_n = 1'b1;
    tick(6);
    rda(3'd3, 32'h00, "t6_cap_t7_pre");
    rd(3'd3, 32'h6F, 32'h00, 32'h6F, "t6_cap");
    rda(3'd0, 32'h6F, "t6_data");
    rda(3'd4, 32'h4, "t6_dblimit");

    tick(3);
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain pending %0d required 0", rd_q.size() + irq_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
